// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the soft-reset controller: register map, sequencer states
// and the bus byte-order helper.
package reset_ctrl_pkg;

  localparam logic [1:0] RST_A_HOLD   = 2'd0;
  localparam logic [1:0] RST_A_PULSE  = 2'd1;
  localparam logic [1:0] RST_A_STATUS = 2'd2;

  typedef enum logic [1:0] {INIT, HOLD, REL, RUN} seq_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/reset_pulse_chan.sv
// One self-timed reset pulse: a loadable down-counter whose non-zero value
// keeps the channel asserted. A load while counting restarts the full width.
module reset_pulse_chan
  import reset_ctrl_pkg::*;
#(
  parameter int PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  output logic active
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/reset_ctrl.sv
// Soft-reset controller: power-on hold and staggered release, software hold
// bits, self-timed pulses and a byte-reversed register window.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int NCH          = 8,
  parameter int PULSE_CYCLES = 16,
  parameter int STAGGER      = 4
) (
  input  logic           clk,
  input  logic           rst_globl_n,
  input  logic [1:0]     a,
  input  logic [31:0]    d,
  input  logic           we,
  output logic [31:0]    spo,
  output logic [NCH-1:0] rst_out
);

  localparam int TMAX = (PULSE_CYCLES > STAGGER) ? PULSE_CYCLES : STAGGER;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] REL_LAST  = TW'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCH - 1);

  seq_state_t     state;
  logic [TW-1:0]  tmr;
  logic [IW-1:0]  idx;
  logic [NCH-1:0] seq_force;
  logic [NCH-1:0] hold;
  logic [NCH-1:0] pulse_active;
  logic [NCH-1:0] load;
  logic [31:0]    wr;
  logic [31:0]    rd;
  logic           wr_ok;
  logic           busy;
  logic           clr;
  logic           unused_wr;

  assign wr        = bswap32(d);
  assign unused_wr = ^wr;
  assign clr       = ~rst_globl_n;
  assign wr_ok     = we && rst_globl_n && (state != INIT);
  assign busy      = (state != RUN);
  assign load      = (wr_ok && a == RST_A_PULSE) ? wr[NCH-1:0] : '0;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    reset_pulse_chan #(.PULSE_CYCLES(PULSE_CYCLES)) u_chan (
      .clk    (clk),
      .clr    (clr),
      .load   (load[i]),
      .active (pulse_active[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_globl_n)
      hold <= '0;
    else if (wr_ok && a == RST_A_HOLD)
      hold <= wr[NCH-1:0];
  end

  // Channel 0 drops on the HOLD exit edge; later channels follow every STAGGER cycles.
  always_ff @(posedge clk) begin
    if (!rst_globl_n) begin
      state     <= INIT;
      seq_force <= '1;
      tmr       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        INIT: begin
          state <= HOLD;
          tmr   <= '0;
        end
        HOLD: begin
          if (tmr == HOLD_LAST) begin
            tmr <= '0;
            if (STAGGER == 0 || NCH == 1) begin
              seq_force <= '0;
              state     <= RUN;
            end else begin
              seq_force[0] <= 1'b0;
              idx          <= IW'(1);
              state        <= REL;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        REL: begin
          if (tmr == REL_LAST) begin
            tmr            <= '0;
            seq_force[idx] <= 1'b0;
            idx            <= idx + IW'(1);
            if (idx == LAST_IDX)
              state <= RUN;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_out = hold | pulse_active | seq_force;

  always_comb begin
    rd = '0;
    case (a)
      RST_A_HOLD:   rd[NCH-1:0] = hold;
      RST_A_PULSE:  rd[NCH-1:0] = pulse_active;
      RST_A_STATUS: begin
        rd[NCH-1:0] = rst_out;
        rd[31]      = busy;
      end
      default: ;
    endcase
  end

  assign spo = bswap32(rd);

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: a timeline model of release times and pulse end times,
// checked every cycle on two instances (STAGGER=4 and STAGGER=0), plus literal checkpoints.
module tb_reset_ctrl;

  localparam int NCH = 8;
  localparam int PC  = 16;

  logic        clk = 1'b0;
  logic        rst_globl_n;
  logic        we;
  logic [1:0]  a;
  logic [31:0] d;
  logic [31:0] spo4, spo0;
  logic [7:0]  out4, out0;

  always #5 clk = ~clk;

  reset_ctrl #(.NCH(NCH), .PULSE_CYCLES(PC), .STAGGER(4)) dut (
    .clk(clk), .rst_globl_n(rst_globl_n), .a(a), .d(d), .we(we),
    .spo(spo4), .rst_out(out4)
  );

  reset_ctrl #(.NCH(NCH), .PULSE_CYCLES(PC), .STAGGER(0)) dut0 (
    .clk(clk), .rst_globl_n(rst_globl_n), .a(a), .d(d), .we(we),
    .spo(spo0), .rst_out(out0)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         e0       = 0;
  bit         in_init  = 1'b1;
  bit         armed    = 1'b0;
  logic [7:0] hold_m   = '0;
  int         pend[NCH];

  function automatic logic [31:0] rev(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: edge count, time of first released edge, hold bits, per-channel pulse end edge.
  always @(posedge clk) begin
    logic [31:0] w;
    cyc = cyc + 1;
    if (!rst_globl_n) begin
      in_init = 1'b1;
      armed   = 1'b1;
      hold_m  = '0;
      for (int i = 0; i < NCH; i++) pend[i] = 0;
    end else if (in_init) begin
      in_init = 1'b0;
      e0      = cyc;
    end else if (we) begin
      w = rev(d);
      if (a == 2'd0)
        hold_m = w[7:0];
      else if (a == 2'd1)
        for (int i = 0; i < NCH; i++) if (w[i]) pend[i] = cyc + PC;
    end
  end

  function automatic logic [7:0] exp_out(input int s);
    logic [7:0] r;
    for (int k = 0; k < NCH; k++)
      r[k] = hold_m[k] | (cyc < pend[k]) | in_init | (cyc < e0 + PC + k * s);
    return r;
  endfunction

  function automatic logic exp_busy(input int s);
    return in_init || (cyc < e0 + PC + (NCH - 1) * s);
  endfunction

  function automatic logic [31:0] exp_spo(input int s);
    logic [31:0] w;
    w = '0;
    case (a)
      2'd0: w[7:0] = hold_m;
      2'd1: for (int k = 0; k < NCH; k++) w[k] = (cyc < pend[k]);
      2'd2: begin
        w[7:0] = exp_out(s);
        w[31]  = exp_busy(s);
      end
      default: ;
    endcase
    return rev(w);
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("out_s4", out4, exp_out(4));
      chk("out_s0", out0, exp_out(0));
      chk("spo_s4", spo4, exp_spo(4));
      chk("spo_s0", spo0, exp_spo(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    a  = addr;
    d  = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst_globl_n = 1'b0;
    we = 1'b0;
    a  = 2'd2;
    d  = '0;

    repeat (3) tick();
    chk("reset_out", out4, 32'hFF);
    chk("reset_status", spo4, 32'hFF000080);
    chk("reset_out_s0", out0, 32'hFF);

    // Power-on sequence
    rst_globl_n = 1'b1;
    tick();
    chk("por_e0", out4, 32'hFF);
    repeat (15) tick();
    chk("por_e0p15", out4, 32'hFF);
    chk("s0_e0p15", out0, 32'hFF);
    tick();
    chk("por_e0p16", out4, 32'hFE);
    chk("s0_e0p16", out0, 32'h00);
    chk("s0_status_e0p16", spo0, 32'h0);
    repeat (27) tick();
    chk("por_e0p43", out4, 32'h80);
    chk("status_e0p43", spo4, 32'h80000080);
    tick();
    chk("por_e0p44", out4, 32'h00);
    chk("status_e0p44", spo4, 32'h0);
    repeat (3) tick();

    // Software pulse on channels 0 and 2
    wr(2'd1, 32'h05000000);
    a = 2'd1;
    #1;
    chk("pulse_out_w", out4, 32'h05);
    chk("pulse_rd_w", spo4, 32'h05000000);
    repeat (15) tick();
    chk("pulse_out_w15", out4, 32'h05);
    tick();
    chk("pulse_out_w16", out4, 32'h00);
    chk("pulse_rd_w16", spo4, 32'h0);

    // Retrigger after 10 cycles extends to 26 cycles total
    wr(2'd1, 32'h01000000);
    hi = out4[0] ? 1 : 0;
    for (int i = 1; i < 60; i++) begin
      if (i == 10) wr(2'd1, 32'h01000000);
      else tick();
      if (out4[0]) hi++;
      else break;
    end
    chk("retrig_len", hi, 26);

    // Hold overlapping a pulse on channel 7
    wr(2'd0, 32'h80000000);
    chk("hold_only", out4, 32'h80);
    wr(2'd1, 32'h80000000);
    a = 2'd2;
    #1;
    chk("status_held", spo4, 32'h80000000);
    repeat (4) tick();
    wr(2'd0, 32'h0);
    chk("ovl_w5", out4, 32'h80);
    repeat (10) tick();
    chk("ovl_w15", out4, 32'h80);
    tick();
    chk("ovl_w16", out4, 32'h00);
    a = 2'd0;
    #1;
    chk("hold_rd_clear", spo4, 32'h0);

    // Mid-operation reset while releasing channel 3
    rst_globl_n = 1'b0;
    tick();
    rst_globl_n = 1'b1;
    tick();
    repeat (18) tick();
    wr(2'd0, 32'h02000000);
    repeat (5) tick();
    chk("rel_idx3", out4, 32'hFA);
    rst_globl_n = 1'b0;
    tick();
    chk("midrst_out", out4, 32'hFF);
    chk("midrst_out_s0", out0, 32'hFF);
    a = 2'd0;
    #1;
    chk("midrst_hold", spo4, 32'h0);
    tick();
    rst_globl_n = 1'b1;
    tick();
    chk("rst2_e0", out4, 32'hFF);
    repeat (15) tick();
    chk("rst2_e0p15", out4, 32'hFF);
    tick();
    chk("rst2_e0p16", out4, 32'hFE);
    repeat (28) tick();
    a = 2'd2;
    #1;
    chk("rst2_e0p44", out4, 32'h00);
    chk("rst2_status", spo4, 32'h0);

    // Unmapped address: writes ignored, reads zero
    wr(2'd3, 32'hFFFFFFFF);
    a = 2'd3;
    #1;
    chk("a3_rd_s4", spo4, 32'h0);
    chk("a3_rd_s0", spo0, 32'h0);
    chk("a3_out_s4", out4, 32'h00);
    chk("a3_out_s0", out0, 32'h00);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_ctrl.md
# reset_ctrl

Parametrised soft-reset controller. It drives NCH active-high per-peripheral reset lines from one bus-mapped register window. After a global reset it holds every channel for a minimum pulse width, then releases the channels one at a time at a fixed stagger. It also provides software hold bits, self-timed reset pulses and status readback. It sits on the peripheral bus next to the interrupt controller and feeds the rst_* inputs of GPIO, UART, SD card, video, USB, PSRAM, interrupt and MMU.

## Interface
- NCH, 8, number of reset channels; legal range 1..31.
- PULSE_CYCLES, 16, minimum reset width after global reset, and the width of software pulses; must be ≥1.
- STAGGER, 4, cycles between successive channel releases after global reset; 0 releases all channels together.
- clk  in  1  system clock; all logic on its rising edge.
- rst_globl_n  in  1  global reset, synchronous, active-low.
- a  in  2  register word address.
- d  in  32  write data; bus byte order is reversed, so the internal value is {d[7:0], d[15:8], d[23:16], d[31:24]}.
- we  in  1  write strobe; one-cycle write.
- spo  out  32  read data; combinational from a; same byte reversal as d.
- rst_out  out  NCH  active-high reset per channel. Channel 0 is released first.

## Operation
- Registers, after byte reversal:
  - a=0 HOLD, read/write: bit i=1 holds channel i in reset until cleared.
  - a=1 PULSE, write: each 1 bit loads channel i's counter with PULSE_CYCLES. Read returns pulse-active bits.
  - a=2 STATUS, read-only: [NCH-1:0] = rst_out, [31] = busy (sequencer not in RUN).
  - a=3: reads 0; writes ignored. Bits at or above NCH: read 0, writes ignored.
- Output equation: rst_out[i] = hold[i] | pulse_active[i] | seq_force[i]. pulse_active[i] means cnt[i] != 0.
- Sequencer states:
  - INIT: entered while rst_globl_n=0; seq_force all 1, tmr=0, idx=0.
  - HOLD: count PULSE_CYCLES cycles.
  - REL: clear seq_force[idx], then wait STAGGER cycles before the next release.
  - RUN: idle; busy=0.
- Transitions:
  - INIT→HOLD on the first edge where rst_globl_n=1.
  - HOLD→REL when tmr reaches PULSE_CYCLES-1.
  - REL advances idx each STAGGER cycles.
  - REL→RUN on the edge that releases channel NCH-1.
- Register writes are accepted in every state except INIT. seq_force ORs on top of them, so a write never shortens the power-on hold.
- Pulse retrigger: writing 1 to a channel that is already active reloads its counter to PULSE_CYCLES. The pulse is extended, not stacked.
- HOLD and PULSE are independent. Clearing HOLD while a pulse is active leaves the channel asserted until the pulse ends.
- Global reset at any time aborts everything:
  - HOLD=0, counters=0, seq_force=all 1, state INIT.
  - rst_out is all 1 from the first edge that samples rst_globl_n=0.

## Timing
- Reset values: rst_out = all 1, HOLD = 0, counters = 0, busy = 1, state INIT.
- Let E0 be the first edge that samples rst_globl_n=1. Channel k's seq_force clears at edge E0+PULSE_CYCLES+k·STAGGER. busy clears on the same edge as channel NCH-1.
- HOLD write: rst_out changes on the edge that samples we=1. No extra latency.
- PULSE write at edge W: rst_out[i]=1 from W through W+PULSE_CYCLES-1. It reads 0 after edge W+PULSE_CYCLES, if not otherwise held.
- spo is combinational. A read in the same cycle as a write to the same register returns the pre-write value.
- Counter width: $clog2(PULSE_CYCLES+1). The sequencer timer is wide enough for max(PULSE_CYCLES, STAGGER). idx width: $clog2(NCH) with a minimum of 1.

## Structure
- Shared package reset_ctrl_pkg:
  - address constants RST_A_HOLD=0, RST_A_PULSE=1, RST_A_STATUS=2
  - state enum {INIT, HOLD, REL, RUN}
  - function bswap32.
- One sub-module, reset_pulse_chan: a per-channel loadable down-counter with load, an active output, and synchronous clear. It is instantiated NCH times in a generate loop.
- The top level holds the HOLD register, the sequencer FSM, the seq_force vector and the read mux.

## Test plan
- Power-on sequence. Parameters NCH=8, PULSE_CYCLES=16, STAGGER=4. Drop rst_globl_n for 3 cycles, then release.
  - rst_out=8'hFF through E0+15.
  - Bit 0 clears at E0+16, bit 7 at E0+44.
  - busy falls at E0+44.
- Software pulse. In RUN, write PULSE with internal value 0x05 (d=32'h05000000).
  - rst_out=8'h05 for exactly 16 cycles, then 8'h00.
  - PULSE reads 0x05 during the pulse, then 0.
- Retrigger. Write PULSE 0x01, then write 0x01 again 10 cycles later.
  - rst_out[0] stays high for 26 cycles in total.
- Hold overlap. Write HOLD 0x80, then PULSE 0x80, then HOLD 0x00 five cycles later.
  - rst_out[7] stays high until the pulse ends, 16 cycles after the pulse write.
  - STATUS reads d-order 32'h80000000 while the channel is held.
- Mid-operation reset. Assert rst_globl_n=0 during REL at idx=3 with HOLD=0x02.
  - rst_out=8'hFF on the next edge; HOLD reads 0.
  - The full power-on sequence restarts from E0.
- STAGGER=0 variant. All channels release together at E0+PULSE_CYCLES. A write to a=3 has no effect and reads 0.
